// File: rtl/mmu_port_arbiter.sv
// rtl/mmu_port_arbiter.sv - shares the MMU AXI4-Lite slave port between instruction fetch and load/store
// Optional MMU_ARB_RR_EN: round-robin arbitration instead of fixed data priority with a starvation guard.

module mmu_port_arbiter #(
   parameter int STARVE_MAX = 8,
   parameter int CNT_W      = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_done,
   output logic [31:0] i_rdata,
   output logic        i_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic        d_done,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic [31:0] c_axi_araddr,
   output logic        c_axi_arvalid,
   input  logic        c_axi_arready,
   output logic [31:0] c_axi_awaddr,
   output logic        c_axi_awvalid,
   input  logic        c_axi_awready,
   output logic [31:0] c_axi_wdata,
   output logic [3:0]  c_axi_wstrb,
   output logic        c_axi_wvalid,
   input  logic        c_axi_wready,
   input  logic [31:0] c_axi_rdata,
   input  logic [1:0]  c_axi_rresp,
   input  logic        c_axi_rvalid,
   output logic        c_axi_rready,
   input  logic [1:0]  c_axi_bresp,
   input  logic        c_axi_bvalid,
   output logic        c_axi_bready,
   output logic        is_instr,
   input  logic        mmu_exc
);

   typedef enum logic [2:0] {IDLE, I_AR, I_R, D_AR, D_R, D_AW, D_W, D_B} state_t;

   state_t      r_state, w_next;
   logic        w_arb, w_pick_i, w_grant_i, w_grant_d;
   logic [31:0] r_araddr, r_awaddr, r_wdata, r_i_rdata, r_d_rdata;
   logic [3:0]  r_wstrb;
   logic        r_i_done, r_i_err, r_d_done, r_d_err;
   logic        w_unused;

`ifdef MMU_ARB_RR_EN
   logic        r_last_d;
`else
   logic [CNT_W-1:0] r_cnt;
`endif

   assign w_unused = c_axi_rresp[0] ^ c_axi_bresp[0];

   // No arbitration in a done cycle: the finishing requester's req there still belongs to the old request.
   always_comb begin
      w_arb = (r_state == IDLE) && !r_i_done && !r_d_done;
`ifdef MMU_ARB_RR_EN
      w_pick_i = (i_req && d_req) ? r_last_d : i_req;
`else
      w_pick_i = i_req && (!d_req || (r_cnt == CNT_W'(STARVE_MAX)));
`endif
      w_grant_i = w_arb && i_req && w_pick_i;
      w_grant_d = w_arb && d_req && !w_pick_i;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state   <= IDLE;
         r_araddr  <= '0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_i_rdata <= '0;
         r_i_err   <= 1'b0;
         r_i_done  <= 1'b0;
         r_d_rdata <= '0;
         r_d_err   <= 1'b0;
         r_d_done  <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_i_done <= 1'b0;
         r_d_done <= 1'b0;
         if (w_grant_i) r_araddr <= i_addr;
         if (w_grant_d) begin
            if (d_we) begin
               r_awaddr <= d_addr;
               r_wdata  <= d_wdata;
               r_wstrb  <= d_wstrb;
            end else begin
               r_araddr <= d_addr;
            end
         end
         if ((r_state == I_R) && c_axi_rvalid) begin
            r_i_rdata <= c_axi_rdata;
            r_i_err   <= c_axi_rresp[1] | mmu_exc;
            r_i_done  <= 1'b1;
         end
         if ((r_state == D_R) && c_axi_rvalid) begin
            r_d_rdata <= c_axi_rdata;
            r_d_err   <= c_axi_rresp[1] | mmu_exc;
            r_d_done  <= 1'b1;
         end
         if ((r_state == D_B) && c_axi_bvalid) begin
            r_d_err  <= c_axi_bresp[1] | mmu_exc;
            r_d_done <= 1'b1;
         end
      end
   end

`ifdef MMU_ARB_RR_EN
   always_ff @(posedge clk) begin
      if (!rstn)          r_last_d <= 1'b0;
      else if (w_grant_i) r_last_d <= 1'b0;
      else if (w_grant_d) r_last_d <= 1'b1;
   end
`else
   always_ff @(posedge clk) begin
      if (!rstn || !i_req || w_grant_i) r_cnt <= '0;
      else if (w_grant_d)               r_cnt <= r_cnt + 1'b1;
   end
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_grant_i)      w_next = I_AR;
            else if (w_grant_d) w_next = d_we ? D_AW : D_AR;
         end
         I_AR:    if (c_axi_arready) w_next = I_R;
         D_AR:    if (c_axi_arready) w_next = D_R;
         I_R:     if (c_axi_rvalid)  w_next = IDLE;
         D_R:     if (c_axi_rvalid)  w_next = IDLE;
         D_AW:    if (c_axi_awready) w_next = D_W;
         D_W:     if (c_axi_wready)  w_next = D_B;
         D_B:     if (c_axi_bvalid)  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Channel valids/readies decode straight from the registered state, so they are glitch-free.
   always_comb begin
      c_axi_arvalid = (r_state == I_AR) || (r_state == D_AR);
      c_axi_rready  = (r_state == I_R)  || (r_state == D_R);
      c_axi_awvalid = (r_state == D_AW);
      c_axi_wvalid  = (r_state == D_W);
      c_axi_bready  = (r_state == D_B);
      is_instr      = (r_state == I_AR) || (r_state == I_R);
   end

   assign c_axi_araddr = r_araddr;
   assign c_axi_awaddr = r_awaddr;
   assign c_axi_wdata  = r_wdata;
   assign c_axi_wstrb  = r_wstrb;
   assign i_done       = r_i_done;
   assign i_rdata      = r_i_rdata;
   assign i_err        = r_i_err;
   assign d_done       = r_d_done;
   assign d_rdata      = r_d_rdata;
   assign d_err        = r_d_err;

endmodule
